// File: rtl/modport_axil_regs.sv
`default_nettype none
// ============================================================================
// Module  : modport_axil_regs
// Brief   : AXI4-Lite slave register bank, one outstanding write and read.
// Revision: 1.0
// ============================================================================
module modport_axil_regs #(
    parameter int          A_BITS   = 32,
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = 32'h0000_C0DE
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [A_BITS-1:0]        i_awaddr,
    input  logic                     i_awvalid,
    output logic                     o_awready,
    input  logic [31:0]              i_wdata,
    input  logic [3:0]               i_wstrb,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    output logic [1:0]               o_bresp,
    output logic                     o_bvalid,
    input  logic                     i_bready,
    input  logic [A_BITS-1:0]        i_araddr,
    input  logic                     i_arvalid,
    output logic                     o_arready,
    output logic [31:0]              o_rdata,
    output logic [1:0]               o_rresp,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [NUM_REGS*32-1:0]   o_regs
);

    localparam int                IDX_W          = $clog2(NUM_REGS);
    localparam logic [A_BITS-1:0] c_ADDR_LIMIT   = A_BITS'(NUM_REGS * 4);
    localparam logic [1:0]        c_RESP_OKAY    = 2'b00;
    localparam logic [1:0]        c_RESP_SLVERR  = 2'b10;

    // Register 0 is the constant ID word, so only 1..NUM_REGS-1 are storage.
    logic [31:0]       r_regs [1:NUM_REGS-1];

    logic              r_awready;
    logic              r_wready;
    logic              r_aw_held;
    logic              r_w_held;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [A_BITS-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;

    logic              r_arready;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_have_aw;
    logic              w_have_w;
    logic              w_commit;
    logic              w_aw_held_nxt;
    logic              w_w_held_nxt;
    logic              w_bvalid_nxt;
    logic [A_BITS-1:0] w_wr_addr;
    logic [31:0]       w_wr_data;
    logic [3:0]        w_wr_strb;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_wr_in_range;

    logic              w_ar_hs;
    logic              w_rvalid_nxt;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_in_range;
    logic [31:0]       w_rd_word;

    // A channel counts as present if it was latched earlier or handshakes now.
    assign w_aw_hs       = i_awvalid && r_awready;
    assign w_w_hs        = i_wvalid && r_wready;
    assign w_have_aw     = r_aw_held || w_aw_hs;
    assign w_have_w      = r_w_held || w_w_hs;
    assign w_commit      = w_have_aw && w_have_w;
    assign w_aw_held_nxt = w_have_aw && !w_commit;
    assign w_w_held_nxt  = w_have_w && !w_commit;
    assign w_bvalid_nxt  = w_commit || (r_bvalid && !i_bready);

    assign w_wr_addr     = r_aw_held ? r_awaddr : i_awaddr;
    assign w_wr_data     = r_w_held ? r_wdata : i_wdata;
    assign w_wr_strb     = r_w_held ? r_wstrb : i_wstrb;
    assign w_wr_idx      = w_wr_addr[2 +: IDX_W];
    assign w_wr_in_range = (w_wr_addr < c_ADDR_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
            r_wready  <= !w_w_held_nxt && !w_bvalid_nxt;
            if (w_aw_hs) begin
                r_awaddr <= i_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_wr_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 1; k < NUM_REGS; k++) begin
            if (i_rst) begin
                r_regs[k] <= '0;
            end else if (w_commit && w_wr_in_range && (w_wr_idx == IDX_W'(k))) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wr_strb[b]) begin
                        r_regs[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign w_ar_hs       = i_arvalid && r_arready;
    assign w_rvalid_nxt  = w_ar_hs || (r_rvalid && !i_rready);
    assign w_rd_idx      = i_araddr[2 +: IDX_W];
    assign w_rd_in_range = (i_araddr < c_ADDR_LIMIT);

    always_comb begin
        w_rd_word = ID_VALUE;
        if (w_rd_idx != '0) begin
            w_rd_word = r_regs[w_rd_idx];
        end
    end

    // Read data is captured before any same-edge write lands, so it sees the old value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_RESP_OKAY;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_in_range ? w_rd_word : 32'h0;
                r_rresp <= w_rd_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
            end
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;

    assign o_regs[31:0] = ID_VALUE;
    for (genvar k = 1; k < NUM_REGS; k++) begin : g_regs_out
        assign o_regs[k*32 +: 32] = r_regs[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_modport_axil_regs.sv
`default_nettype none
// ============================================================================
// Module  : tb_modport_axil_regs
// Brief   : Self-checking bench for modport_axil_regs (table + scoreboard).
// Revision: 1.0
// ============================================================================
module tb_modport_axil_regs;

    localparam int          NREGS = 16;
    localparam logic [31:0] ID    = 32'h0000_C0DE;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            awaddr;
    logic                   awvalid;
    logic                   awready;
    logic [31:0]            wdata;
    logic [3:0]             wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [31:0]            araddr;
    logic                   arvalid;
    logic                   arready;
    logic [31:0]            rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;
    logic [NREGS*32-1:0]    regs;

    modport_axil_regs #(.A_BITS(32), .NUM_REGS(NREGS), .ID_VALUE(ID)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(awready),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_wvalid(wvalid), .o_wready(wready),
        .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
        .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid), .i_rready(rready),
        .o_regs(regs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    logic [1:0]  b_q[$];
    rexp_t       r_q[$];
    logic [31:0] m_regs[NREGS];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          b_hs_cnt = 0;
    vec_t        vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string name);
        logic [NREGS*32-1:0] e;
        int bad_k;
        for (int k = 0; k < NREGS; k++) e[k*32 +: 32] = m_regs[k];
        n_cmp++;
        if (regs !== e) begin
            n_bad++;
            bad_k = 0;
            for (int k = NREGS-1; k >= 0; k--) if (regs[k*32 +: 32] !== e[k*32 +: 32]) bad_k = k;
            $display("FAIL %s: o_regs word %0d got %h expected %h", name, bad_k,
                     regs[bad_k*32 +: 32], e[bad_k*32 +: 32]);
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr[5:2]);
        if (addr < 32'(NREGS*4) && idx != 0)
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
    endtask

    task automatic model_reset();
        m_regs[0] = ID;
        for (int k = 1; k < NREGS; k++) m_regs[k] = 32'h0;
    endtask

    // One clock: scoreboard sampling at negedge, then return just after posedge.
    task automatic step();
        rexp_t e;
        @(negedge clk);
        if (!rst && bvalid && bready) begin
            b_hs_cnt++;
            if (b_q.size() == 0) check("b_unexpected", 1, 0);
            else check("bresp", bresp, b_q.pop_front());
        end
        if (!rst && rvalid && rready) begin
            if (r_q.size() == 0) check("r_unexpected", 1, 0);
            else begin
                e = r_q.pop_front();
                check("rdata", rdata, e.data);
                check("rresp", rresp, e.resp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(b_q.size() + r_q.size()), 0);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_at, input int w_at, input logic [1:0] exp_resp,
                             input bit wait_resp);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int c = 0;
        int cnt0 = b_hs_cnt;
        b_q.push_back(exp_resp);
        model_write(addr, data, strb);
        while (!(aw_done && w_done) && c < 50) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (c >= aw_at);
            wvalid  = !w_done && (c >= w_at);
            if (aw_done) check("awready_low_while_held", awready, 0);
            if (w_done)  check("wready_low_while_held", wready, 0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            step();
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("write_accept_timeout", 64'(aw_done && w_done), 1);
        if (wait_resp) begin
            drain();
            check("bvalid_pulse_count", 64'(b_hs_cnt - cnt0), 1);
            check("awready_after_b", awready, 1);
            check("wready_after_b", wready, 1);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input bit wait_resp);
        bit done = 0, hs;
        int c = 0;
        r_q.push_back('{data: exp_data, resp: exp_resp});
        while (!done && c < 50) begin
            araddr  = addr;
            arvalid = 1'b1;
            hs = arready;
            step();
            done = hs;
            c++;
        end
        arvalid = 1'b0;
        check("read_accept_timeout", 64'(done), 1);
        if (wait_resp) begin
            drain();
            check("arready_after_r", arready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  hold_resp;
        logic [31:0] hold_data;

        rst = 1'b1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 1'b1; araddr = '0; arvalid = 0; rready = 1'b1;
        model_reset();

        vecs[0]  = '{1'b0, 32'h00, 32'h0000C0DE, 4'h0, 2'b00};
        vecs[1]  = '{1'b0, 32'h04, 32'h00000000, 4'h0, 2'b00};
        vecs[2]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 2'b00};
        vecs[3]  = '{1'b0, 32'h08, 32'hDEADBEEF, 4'h0, 2'b00};
        vecs[4]  = '{1'b1, 32'h0C, 32'hAAAAAAAA, 4'hF, 2'b00};
        vecs[5]  = '{1'b1, 32'h0C, 32'h11223344, 4'h5, 2'b00};
        vecs[6]  = '{1'b0, 32'h0C, 32'hAA22AA44, 4'h0, 2'b00};
        vecs[7]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 2'b10};
        vecs[8]  = '{1'b0, 32'h40, 32'h00000000, 4'h0, 2'b10};
        vecs[9]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 2'b00};
        vecs[10] = '{1'b0, 32'h00, 32'h0000C0DE, 4'h0, 2'b00};
        vecs[11] = '{1'b1, 32'h3C, 32'h0BADF00D, 4'h0, 2'b00};
        vecs[12] = '{1'b0, 32'h3C, 32'h00000000, 4'h0, 2'b00};
        vecs[13] = '{1'b1, 32'h3E, 32'h55667788, 4'hF, 2'b00};
        vecs[14] = '{1'b0, 32'h0B, 32'hDEADBEEF, 4'h0, 2'b00};

        @(posedge clk); #1;
        step();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check_regs("rst_regs");
        rst = 1'b0;
        step();
        check("post_rst_awready", awready, 1);
        check("post_rst_wready", wready, 1);
        check("post_rst_arready", arready, 1);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr)
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, vecs[i].resp, 1'b1);
            else
                axi_read(vecs[i].addr, vecs[i].data, vecs[i].resp, 1'b1);
            check_regs("table_regs");
        end

        // AW three cycles ahead of W, then W ahead of AW.
        axi_write(32'h10, 32'hCAFE0010, 4'hF, 0, 3, 2'b00, 1'b1);
        axi_write(32'h14, 32'hBEEF0014, 4'hF, 2, 0, 2'b00, 1'b1);
        axi_read(32'h10, 32'hCAFE0010, 2'b00, 1'b1);
        axi_read(32'h14, 32'hBEEF0014, 2'b00, 1'b1);
        check_regs("split_regs");

        // Read and write to the same register on the same edge.
        b_q.push_back(2'b00);
        r_q.push_back('{data: 32'h0, resp: 2'b00});
        model_write(32'h18, 32'h00000077, 4'hF);
        awaddr = 32'h18; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'h18; arvalid = 1;
        check("same_edge_ready", {awready, wready, arready}, 3'b111);
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        drain();
        axi_read(32'h18, 32'h00000077, 2'b00, 1'b1);

        // Write response stalled for 5 cycles; a new AW must not be taken.
        bready = 1'b0;
        axi_write(32'h1C, 32'h99999999, 4'hF, 0, 0, 2'b00, 1'b0);
        awaddr = 32'h20; awvalid = 1'b1;
        hold_resp = bresp;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", bvalid, 1);
            check("stall_bresp", bresp, hold_resp);
            check("stall_awready", awready, 0);
            check("stall_wready", wready, 0);
            step();
        end
        awvalid = 1'b0;
        bready = 1'b1;
        drain();
        check_regs("stall_b_regs");

        // Read response stalled for 5 cycles; a new AR must not be taken.
        rready = 1'b0;
        axi_read(32'h1C, 32'h99999999, 2'b00, 1'b0);
        araddr = 32'h08; arvalid = 1'b1;
        hold_data = rdata;
        for (int i = 0; i < 5; i++) begin
            check("stall_rvalid", rvalid, 1);
            check("stall_rdata", rdata, hold_data);
            check("stall_arready", arready, 0);
            step();
        end
        arvalid = 1'b0;
        rready = 1'b1;
        drain();

        // Reset with a write response pending.
        bready = 1'b0;
        axi_write(32'h20, 32'h12345678, 4'hF, 0, 0, 2'b00, 1'b0);
        rst = 1'b1;
        step();
        b_q.delete();
        model_reset();
        check("midrst_bvalid", bvalid, 0);
        check("midrst_ready", {awready, wready, arready, rvalid}, 4'b0000);
        check_regs("midrst_regs");
        rst = 1'b0;
        bready = 1'b1;
        step();
        check("midrst_recover_ready", {awready, wready, arready}, 3'b111);

        // Latched AW must be discarded by reset.
        awaddr = 32'h24; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        axi_write(32'h28, 32'h0F0F0F0F, 4'hF, 3, 0, 2'b00, 1'b1);
        check_regs("aw_discard_regs");
        axi_read(32'h24, 32'h00000000, 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
